// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: CS_n framing, SCLK divider, mode 0-3 sample/shift strobes.
// Optional SPI_BURST_EN adds a Hold input and a GAP state for back-to-back words under one CS_n.
module spi_xfer_ctrl #(
    parameter int WordLen  = 8,
    parameter int DivWidth = 8,
    parameter int CsSetup  = 2,
    parameter int CsHold   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic                Cpol,
    input  logic                Cpha,
    input  logic [DivWidth-1:0] ClkDiv,
`ifdef SPI_BURST_EN
    input  logic                Hold,
`endif
    output logic                Busy,
    output logic                Done,
    output logic                SCLK,
    output logic                CS_n,
    output logic                LoadPISO,
    output logic                ShiftFlg,
    output logic                SCLKEdgeFlg,
    output logic                EnSIPO,
    output logic                EnPISO
);
    localparam int EW   = $clog2(2*WordLen+1);
    localparam int PMAX = (CsSetup > CsHold) ? CsSetup : CsHold;
    localparam int PW   = $clog2(PMAX+1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
`ifdef SPI_BURST_EN
    localparam logic [2:0] GAP   = 3'd4;
`endif

    logic [2:0]          state_q, state_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DivWidth-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
    logic [EW-1:0]       edge_cnt_q, edge_cnt_d;
    logic [PW-1:0]       ph_cnt_q, ph_cnt_d;
    logic                sclk_q, sclk_d, cs_n_q, cs_n_d, done_q, done_d;
    logic                load_q, load_d, shift_q, shift_d, samp_q, samp_d;
    logic                lead, first, last;

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ph_cnt_d   = ph_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
        load_d     = 1'b0;
        shift_d    = 1'b0;
        samp_d     = 1'b0;
        // toggle number is edge_cnt_q+1: odd toggles are leading edges
        lead       = ~edge_cnt_q[0];
        first      = (edge_cnt_q == '0);
        last       = (edge_cnt_q == EW'(2*WordLen-1));
        case (state_q)
            IDLE: begin
                sclk_d = Cpol;
                if (Start && !done_q) begin
                    cpol_d   = Cpol;
                    cpha_d   = Cpha;
                    div_d    = ClkDiv;
                    cs_n_d   = 1'b0;
                    load_d   = 1'b1;
                    ph_cnt_d = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                ph_cnt_d = ph_cnt_q + 1'b1;
                if (ph_cnt_q == PW'(CsSetup-1)) begin
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == div_q) begin
                    div_cnt_d  = '0;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    sclk_d     = ~sclk_q;
                    samp_d     = lead ^ cpha_q;
                    // the unpaired shift edge (last in mode CPHA=0, first in CPHA=1) is dropped
                    shift_d    = ~(lead ^ cpha_q) & ~(cpha_q ? first : last);
                    if (last) begin
                        sclk_d   = cpol_q;
                        ph_cnt_d = '0;
                        state_d  = HOLD;
`ifdef SPI_BURST_EN
                        if (Hold) begin
                            done_d  = 1'b1;
                            state_d = GAP;
                        end
`endif
                    end
                end
            end
            HOLD: begin
                ph_cnt_d = ph_cnt_q + 1'b1;
                if (ph_cnt_q == PW'(CsHold-1)) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef SPI_BURST_EN
            GAP: begin
                if (Start) begin
                    cpol_d     = Cpol;
                    cpha_d     = Cpha;
                    div_d      = ClkDiv;
                    load_d     = 1'b1;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = XFER;
                end else if (!Hold) begin
                    ph_cnt_d = '0;
                    state_d  = HOLD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            ph_cnt_q   <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            samp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
        end
    end

    assign Busy        = ~cs_n_q;
    assign Done        = done_q;
    assign SCLK        = sclk_q;
    assign CS_n        = cs_n_q;
    assign LoadPISO    = load_q;
    assign ShiftFlg    = shift_q;
    assign SCLKEdgeFlg = samp_q;
    assign EnSIPO      = ~cs_n_q;
    assign EnPISO      = ~cs_n_q;
endmodule
